// File: rtl/jrb8_serial_mem_host.sv
// Host-side responder for the jrb8 serial memory port: drives sclk/ready, collects the
// PC or RAM address (and write data) from the CPU, and shifts ROM/RAM read data back.
module jrb8_serial_mem_host #(
  parameter int CLK_DIV = 4,
  parameter int ROM_AW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rom_req,
  input  logic              ram_wr_req,
  input  logic              ram_rd_req,
  input  logic              pc_in_flag,
  input  logic              serial_from_cpu,
  output logic              sclk,
  output logic              ready,
  output logic              serial_to_cpu,
  input  logic              load_we,
  input  logic [ROM_AW-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              busy,
  output logic              err
);

  localparam int HW = $clog2(CLK_DIV);
  localparam logic [HW-1:0] HC_MAX = HW'(CLK_DIV - 1);
  // Only the low address bits that can index a memory are kept; upper PC bits shift out.
  localparam int AW = (ROM_AW > 8) ? ROM_AW : 8;

  typedef enum logic [2:0] {IDLE, ADDR, DIN, DOUT, DONE} state_t;
  typedef enum logic [1:0] {REQ_ROM, REQ_WR, REQ_RD} req_t;

  state_t        state, state_next;
  req_t          req_type;
  logic [HW-1:0] hcnt;
  logic [3:0]    bitcnt;
  logic [AW-1:0] addr_sr, addr_next;
  logic [7:0]    data_sr, rd_data;
  logic [7:0]    rom [2**ROM_AW];
  logic [7:0]    ram [256];
  logic          running, fall_event, req_active, abort, last_fall;

  // Handshake: the CPU holds its request flag high for the whole transaction; ready is high
  // while bits move (ADDR/DIN/DOUT), drops in DONE, and the host idles once the flag drops.
  assign running    = (state == ADDR) || (state == DIN) || (state == DOUT);
  assign fall_event = running && sclk && (hcnt == HC_MAX);
  assign addr_next  = {addr_sr[AW-2:0], serial_from_cpu};
  assign rd_data    = (req_type == REQ_ROM) ? rom[addr_next[ROM_AW-1:0]] : ram[addr_next[7:0]];

  always_comb begin
    req_active = 1'b0;
    case (req_type)
      REQ_ROM: req_active = rom_req;
      REQ_WR:  req_active = ram_wr_req;
      default: req_active = ram_rd_req;
    endcase
  end

  assign abort     = running && !req_active;
  assign last_fall = fall_event &&
                     (bitcnt == ((state == ADDR && req_type == REQ_ROM) ? 4'd15 : 4'd7));

  assign ready         = running;
  assign busy          = (state != IDLE);
  assign serial_to_cpu = (state == DOUT) && data_sr[7];

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (rom_req || ram_wr_req || ram_rd_req) state_next = ADDR;
      ADDR: begin
        if (abort)          state_next = IDLE;
        else if (last_fall) state_next = (req_type == REQ_WR) ? DIN : DOUT;
      end
      DIN, DOUT: begin
        if (abort)          state_next = IDLE;
        else if (last_fall) state_next = DONE;
      end
      DONE: if (!req_active) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_type <= REQ_ROM;
      hcnt     <= '0;
      sclk     <= 1'b0;
      bitcnt   <= '0;
      addr_sr  <= '0;
      data_sr  <= '0;
      err      <= 1'b0;
    end else begin
      if (running && !abort && state_next != DONE) begin
        if (hcnt == HC_MAX) begin
          hcnt <= '0;
          sclk <= ~sclk;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end else begin
        hcnt <= '0;
        sclk <= 1'b0;
      end

      if (!running)        bitcnt <= '0;
      else if (fall_event) bitcnt <= last_fall ? 4'd0 : bitcnt + 4'd1;

      if (state == IDLE) begin
        if (rom_req)         req_type <= REQ_ROM;
        else if (ram_wr_req) req_type <= REQ_WR;
        else if (ram_rd_req) req_type <= REQ_RD;
      end

      if (abort) begin
        err <= 1'b1;
      end else if (fall_event) begin
        case (state)
          ADDR: begin
            addr_sr <= addr_next;
            if (req_type == REQ_ROM && !pc_in_flag) err <= 1'b1;
            if (last_fall) data_sr <= rd_data;
          end
          DIN:     data_sr <= {data_sr[6:0], serial_from_cpu};
          DOUT:    data_sr <= {data_sr[6:0], 1'b0};
          default: data_sr <= data_sr;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (state == DIN && !abort && last_fall) begin
      ram[addr_sr[7:0]] <= {data_sr[6:0], serial_from_cpu};
    end
  end

  // ROM survives reset so a program loaded once stays resident.
  always_ff @(posedge clk) begin
    if (load_we && state == IDLE) rom[load_addr] <= load_data;
  end

endmodule

// File: doc/jrb8_serial_mem_host.md
Name: jrb8_serial_mem_host

Overview:
Host-side responder for the jrb8 CPU's serial memory port. It generates sclk/ready, receives the 16-bit PC or 8-bit RAM address and write data serially from the CPU, and shifts ROM or RAM read data back. It sits on the board/FPGA side, or in the cocotb harness as synthesizable RTL, and connects to the CPU's ui_in[2:0] and uo_out[4:0]. It holds the program ROM, which is loaded through a parallel port while idle, and a 256-byte RAM.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period (>=2)
ROM_AW, 8, ROM address width; ROM depth is 2^ROM_AW bytes

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rom_req  in  1  CPU rom_out_flag
ram_wr_req  in  1  CPU ram_in_flag
ram_rd_req  in  1  CPU ram_out_flag
pc_in_flag  in  1  CPU flag; high while the CPU shifts PC bits
serial_from_cpu  in  1  CPU serial_out
sclk  out  1  serial clock to CPU
ready  out  1  high while a transfer is running
serial_to_cpu  out  1  data bit to CPU
load_we  in  1  ROM load strobe; honoured only in IDLE
load_addr  in  ROM_AW  ROM load address
load_data  in  8  ROM load data
busy  out  1  high whenever state != IDLE
err  out  1  sticky; set on pc_in_flag mismatch or abort; cleared by reset

Behaviour:
- Reset (async, active-low): state=IDLE, sclk=0, ready=0, serial_to_cpu=0, busy=0, err=0, all counters 0. RAM clears to 0; ROM contents are untouched.
- States: IDLE, ADDR, DIN, DOUT, DONE.
- IDLE, request sampled at the clk edge, priority rom_req > ram_wr_req > ram_rd_req:
  - Latch the request type.
  - Set nbits=16 for ROM, 8 for RAM.
  - Go to ADDR with ready=1 and hcnt=0.
- sclk generation:
  - sclk runs only in ADDR, DIN and DOUT; it is low in IDLE and DONE.
  - hcnt counts 0..CLK_DIV-1; at CLK_DIV-1 sclk toggles and hcnt wraps.
  - The CPU launches and samples on sclk rise. The host acts only on the clk edge that drives sclk 1->0, called a "fall event".
- ADDR:
  - Each fall event shifts serial_from_cpu into addr_sr, MSB first, and increments bitcnt.
  - If rom_req, pc_in_flag must be high at every fall event; otherwise set err.
  - After nbits falls, bitcnt resets:
    - ROM -> DOUT with data = rom[addr[ROM_AW-1:0]]; upper PC bits are ignored.
    - RAM read -> DOUT with data = ram[addr[7:0]].
    - RAM write -> DIN.
- DIN: 8 fall events shift serial_from_cpu into data_sr, MSB first. On the 8th fall, ram[addr] <= the assembled byte; go to DONE.
- DOUT:
  - serial_to_cpu = data[7] on entry to DOUT, before the first rise.
  - Each fall event presents the next bit, so each bit is stable across one full sclk rise.
  - After the 8th fall, go to DONE; serial_to_cpu returns to 0.
- DONE: ready=0 and sclk=0. Stay until the latched request is deasserted, then go to IDLE. No re-trigger on a request held high.
- Abort: if the latched request drops in ADDR, DIN or DOUT, then next clk go to IDLE:
  - ready=0, sclk=0.
  - err set.
  - No memory write.
- load_we outside IDLE is ignored, with no write. Simultaneous load_we and a request in IDLE: the load write happens and the request is also accepted on the same edge.
- Latency, ROM fetch: 24 sclk periods = 48*CLK_DIV clk from request to DONE, plus 1 clk for IDLE->ADDR.

Test Plan:
- Reset mid-DOUT: all outputs go to 0 asynchronously. After release with rom_req still high, a fresh transaction starts from ADDR with bitcnt=0.
- ROM fetch: load rom[0x05]=0xA7. Model CPU holds rom_req and pc_in_flag, shifts PC=0x0005 MSB first. Required: bits 1,0,1,0,0,1,1,1 returned on successive rises, then ready=0 after 24 periods, err=0. Dropping rom_req returns to IDLE.
- RAM write then read: write addr 0x3C data 0x5A via ram_wr_req, then read 0x3C via ram_rd_req. Required: 0x5A shifted back MSB first. A read of 0x3D returns 0x00.
- Priority and hold: rom_req and ram_rd_req asserted on the same clk -> 16-bit ADDR phase (ROM). With the request held after DONE, no second transaction occurs.
- Abort: drop ram_wr_req after 4 DIN bits. Required: IDLE next clk, err=1, RAM unchanged at the target address.
- pc_in_flag low during ROM ADDR: transfer completes normally, err=1. load_we during busy: ROM unchanged.
